// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared types and helpers for the memory-controller arbitration slice.
//   arb_state_t       : bank arbiter FSM state encoding.
//   bank_idx_t        : bank index wide enough for any supported bank count.
//   first_valid_from  : round-robin search, first set bit of vec starting
//                       at ptr and wrapping modulo n. Returns ptr when vec
//                       has no set bit in [0, n).
package mem_ctrl_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    localparam int ARB_MAX_BANKS = 32;

    typedef logic [$clog2(ARB_MAX_BANKS)-1:0] bank_idx_t;

    function automatic bank_idx_t first_valid_from(input bank_idx_t ptr,
                                                   input logic [ARB_MAX_BANKS-1:0] vec,
                                                   input int n);
        bank_idx_t sel;
        logic      found;
        int        idx;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < ARB_MAX_BANKS; i++) begin
            if (i < n) begin
                idx = (int'(ptr) + i) % n;
                if (!found && vec[idx[4:0]]) begin
                    sel   = bank_idx_t'(idx);
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/arb_out_fifo.sv
// arb_out_fifo
//   Two-entry in-order FIFO between the bank arbiter and the back-end
//   command generator. A push while full is accepted only when a pop happens
//   in the same cycle, so the count never exceeds two.
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : write strobe and data
//   full          : two entries held
//   pop, dout     : read strobe (ignored when empty) and head data
//   empty         : no entries held
//   count         : number of held entries (0..2)
module arb_out_fifo #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign count = cnt;

endmodule

// File: rtl/bank_arbiter.sv
// bank_arbiter
//   Burst-locked round-robin arbiter over NUM_BANKS per-bank scheduler
//   streams. A granted bank keeps the grant for its whole burst (capped at
//   MAX_BURST transfers) so row-hit streaks stay together; accepted requests
//   are forwarded in order through a 2-entry buffer.
//   Optional macro BANK_ARB_PERF_EN adds saturating per-bank accept counters
//   and a counter of burst-cap exits.
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   valid_i, req_i    : per-bank request valid and word (bank b at [b*REQ_SIZE +: REQ_SIZE])
//   ready_o           : one-hot grant back to the schedulers
//   cmd_valid_o/cmd_req_o/cmd_bank_o/cmd_ready_i : output buffer head handshake
//   perf_grant_cnt_o, perf_cap_cnt_o : performance counters (BANK_ARB_PERF_EN only)
//
// state      | meaning
// ARB_IDLE   | no bank held; pick first valid bank from rr_ptr and grant it
// ARB_LOCKED | lock_bank holds the grant until it drops valid or hits MAX_BURST
module bank_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int REQ_SIZE  = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_BANKS-1:0]          valid_i,
    input  logic [NUM_BANKS*REQ_SIZE-1:0] req_i,
    output logic [NUM_BANKS-1:0]          ready_o,
    output logic                          cmd_valid_o,
    output logic [REQ_SIZE-1:0]           cmd_req_o,
    output logic [$clog2(NUM_BANKS)-1:0]  cmd_bank_o,
    input  logic                          cmd_ready_i
`ifdef BANK_ARB_PERF_EN
    ,
    output logic [NUM_BANKS*16-1:0]       perf_grant_cnt_o,
    output logic [15:0]                   perf_cap_cnt_o
`endif
);

    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t     state, state_nx;
    logic [BW-1:0]  rr_ptr, rr_nx;
    logic [BW-1:0]  lock_bank, lock_nx;
    logic [CW-1:0]  burst_cnt, burst_nx;
    logic [BW-1:0]  grant_rr;
    logic [BW-1:0]  grant_idx;
    logic           space;
    logic           xfer_in;

    logic           fifo_full;
    logic           fifo_empty;
    logic [1:0]     fifo_cnt;
    logic [BW+REQ_SIZE-1:0] fifo_dout;

    // Space is taken from the registered count so ready_o never sees cmd_ready_i.
    assign space    = (fifo_cnt < 2'd2);
    assign grant_rr = BW'(first_valid_from(bank_idx_t'(rr_ptr),
                                           ARB_MAX_BANKS'(valid_i), NUM_BANKS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            lock_bank <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            lock_bank <= lock_nx;
            burst_cnt <= burst_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        rr_nx     = rr_ptr;
        lock_nx   = lock_bank;
        burst_nx  = burst_cnt;
        ready_o   = '0;
        grant_idx = lock_bank;
        case (state)
            ARB_IDLE: begin
                grant_idx = grant_rr;
                if ((|valid_i) && space) begin
                    ready_o[grant_rr] = 1'b1;
                    lock_nx           = grant_rr;
                    burst_nx          = CW'(1);
                    state_nx          = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                // The exit cycle grants nothing; re-arbitration waits for IDLE.
                if (!valid_i[lock_bank] || (burst_cnt == CW'(MAX_BURST))) begin
                    state_nx = ARB_IDLE;
                    rr_nx    = (lock_bank == BW'(NUM_BANKS - 1)) ? '0 : lock_bank + 1'b1;
                end else if (space) begin
                    ready_o[lock_bank] = 1'b1;
                    burst_nx           = burst_cnt + 1'b1;
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
        // Reset must silence the grant immediately, not at the next edge.
        if (rst) ready_o = '0;
    end

    assign xfer_in = |(valid_i & ready_o);

    arb_out_fifo #(
        .WIDTH (BW + REQ_SIZE)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (xfer_in && !fifo_full),
        .din   ({grant_idx, req_i[grant_idx*REQ_SIZE +: REQ_SIZE]}),
        .full  (fifo_full),
        .pop   (cmd_ready_i),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign cmd_valid_o = !fifo_empty;
    assign cmd_req_o   = fifo_dout[REQ_SIZE-1:0];
    assign cmd_bank_o  = fifo_dout[BW+REQ_SIZE-1:REQ_SIZE];

`ifdef BANK_ARB_PERF_EN
    logic [15:0] grant_cnt [NUM_BANKS];
    logic [15:0] cap_cnt;
    logic        cap_exit;

    assign cap_exit = (state == ARB_LOCKED) && (burst_cnt == CW'(MAX_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) grant_cnt[b] <= '0;
            cap_cnt <= '0;
        end else begin
            if (xfer_in && (grant_cnt[grant_idx] != 16'hFFFF))
                grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 16'd1;
            if (cap_exit && (cap_cnt != 16'hFFFF))
                cap_cnt <= cap_cnt + 16'd1;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_perf
        assign perf_grant_cnt_o[b*16 +: 16] = grant_cnt[b];
    end
    assign perf_cap_cnt_o = cap_cnt;
`endif

endmodule

// File: tb/tb_bank_arbiter.sv
// tb_bank_arbiter
//   Directed scenarios followed by random traffic, every cycle compared with
//   a behavioural model (queue-based buffer, rule-based arbitration).
//   Build with BANK_ARB_PERF_EN defined to also check the perf counters.
module tb_bank_arbiter;

    localparam int N  = 4;
    localparam int RS = 32;
    localparam int MB = 8;
    localparam int BW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      valid_i;
    logic [N*RS-1:0]   req_i;
    logic [N-1:0]      ready_o;
    logic              cmd_valid_o;
    logic [RS-1:0]     cmd_req_o;
    logic [BW-1:0]     cmd_bank_o;
    logic              cmd_ready_i;
`ifdef BANK_ARB_PERF_EN
    logic [N*16-1:0]   perf_grant_cnt_o;
    logic [15:0]       perf_cap_cnt_o;
`endif

    bank_arbiter #(.NUM_BANKS(N), .REQ_SIZE(RS), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .req_i       (req_i),
        .ready_o     (ready_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_req_o   (cmd_req_o),
        .cmd_bank_o  (cmd_bank_o),
        .cmd_ready_i (cmd_ready_i)
`ifdef BANK_ARB_PERF_EN
        ,
        .perf_grant_cnt_o (perf_grant_cnt_o),
        .perf_cap_cnt_o   (perf_cap_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit              m_locked;
    int              m_ptr;
    int              m_lock;
    int              m_cnt;
    int              m_cap;
    int              m_grants [N];
    logic [BW-1:0]   q_bank [$];
    logic [RS-1:0]   q_req  [$];
    logic [N-1:0]    last_ready;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_ptr    = 0;
        m_lock   = 0;
        m_cnt    = 0;
        m_cap    = 0;
        for (int b = 0; b < N; b++) m_grants[b] = 0;
        q_bank.delete();
        q_req.delete();
    endtask

    task automatic run_cycle(input logic [N-1:0] v, input logic cr);
        logic [N-1:0] exp_ready;
        logic         exp_v;
        int           g;
        bit           has_space;
        valid_i     = v;
        cmd_ready_i = cr;
        for (int b = 0; b < N; b++) req_i[b*RS +: RS] = $urandom();
        #4;
        has_space = (q_bank.size() < 2);
        exp_ready = '0;
        g         = -1;
        if (!m_locked) begin
            if (v != '0 && has_space) begin
                g        = rr_pick(m_ptr, v);
                m_lock   = g;
                m_cnt    = 1;
                m_locked = 1'b1;
            end
        end else if (!v[m_lock] || m_cnt == MB) begin
            if (m_cnt == MB) m_cap++;
            m_locked = 1'b0;
            m_ptr    = (m_lock + 1) % N;
        end else if (has_space) begin
            g = m_lock;
            m_cnt++;
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_v = (q_bank.size() != 0);

        checks++;
        assert (ready_o === exp_ready) else begin
            errors++;
            $error("FAIL ready_o observed %b expected %b", ready_o, exp_ready);
        end
        checks++;
        assert (cmd_valid_o === exp_v) else begin
            errors++;
            $error("FAIL cmd_valid_o observed %b expected %b", cmd_valid_o, exp_v);
        end
        if (exp_v) begin
            checks++;
            assert (cmd_bank_o === q_bank[0]) else begin
                errors++;
                $error("FAIL cmd_bank_o observed %0d expected %0d", cmd_bank_o, q_bank[0]);
            end
            checks++;
            assert (cmd_req_o === q_req[0]) else begin
                errors++;
                $error("FAIL cmd_req_o observed %h expected %h", cmd_req_o, q_req[0]);
            end
        end
        last_ready = ready_o;

        if (exp_v && cr) begin
            void'(q_bank.pop_front());
            void'(q_req.pop_front());
        end
        if (g >= 0) begin
            q_bank.push_back(BW'(g));
            q_req.push_back(req_i[g*RS +: RS]);
            m_grants[g]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_ready(input string tag, input logic [N-1:0] exp);
        checks++;
        assert (last_ready === exp) else begin
            errors++;
            $error("FAIL %s ready_o observed %b expected %b", tag, last_ready, exp);
        end
    endtask

    initial begin
        logic [N-1:0] rv;
        logic [N-1:0] exp2;
        rst         = 1'b1;
        valid_i     = '0;
        req_i       = '0;
        cmd_ready_i = 1'b0;
        model_reset();
        #12;
        checks++;
        assert (ready_o === 4'b0000) else begin errors++; $error("FAIL rst_ready observed %b expected 0000", ready_o); end
        checks++;
        assert (cmd_valid_o === 1'b0) else begin errors++; $error("FAIL rst_cmd_valid observed %b expected 0", cmd_valid_o); end
        checks++;
        assert (cmd_req_o === 32'h0) else begin errors++; $error("FAIL rst_cmd_req observed %h expected 0", cmd_req_o); end
        checks++;
        assert (cmd_bank_o === 2'd0) else begin errors++; $error("FAIL rst_cmd_bank observed %0d expected 0", cmd_bank_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single bank burst, then rr_ptr lands on bank 2
        for (int i = 0; i < 3; i++) begin
            run_cycle(4'b0010, 1'b1);
            check_ready("t1_grant", 4'b0010);
        end
        run_cycle(4'b0000, 1'b1);
        check_ready("t1_exit", 4'b0000);
        run_cycle(4'b0000, 1'b1);
        run_cycle(4'b0101, 1'b1);
        check_ready("t1_ptr2", 4'b0100);
        run_cycle(4'b0000, 1'b1);
        run_cycle(4'b0000, 1'b1);

        // Pointer wrap after bank 3
        run_cycle(4'b1000, 1'b1);
        check_ready("t3_grant3", 4'b1000);
        run_cycle(4'b0101, 1'b1);
        check_ready("t3_exit", 4'b0000);
        run_cycle(4'b0101, 1'b1);
        check_ready("t3_wrap", 4'b0001);
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b1);

        // Back-pressure stall
        run_cycle(4'b0001, 1'b0);
        check_ready("t4_acc1", 4'b0001);
        run_cycle(4'b0001, 1'b0);
        check_ready("t4_acc2", 4'b0001);
        run_cycle(4'b0001, 1'b0);
        check_ready("t4_stall1", 4'b0000);
        run_cycle(4'b0001, 1'b0);
        check_ready("t4_stall2", 4'b0000);
        run_cycle(4'b0001, 1'b1);
        check_ready("t4_resume0", 4'b0000);
        run_cycle(4'b0001, 1'b1);
        check_ready("t4_resume1", 4'b0001);
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b1);

        // Valid drop exit
        run_cycle(4'b0001, 1'b1);
        check_ready("t6_g1", 4'b0001);
        run_cycle(4'b0011, 1'b1);
        check_ready("t6_g2", 4'b0001);
        run_cycle(4'b0010, 1'b1);
        check_ready("t6_exit", 4'b0000);
        run_cycle(4'b0010, 1'b1);
        check_ready("t6_bank1", 4'b0010);
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b1);
`ifdef BANK_ARB_PERF_EN
        checks++;
        assert (perf_cap_cnt_o === 16'd0) else begin errors++; $error("FAIL t6_nocap observed %0d expected 0", perf_cap_cnt_o); end
`endif

        // Reset mid-burst with two entries buffered
        run_cycle(4'b0101, 1'b0);
        run_cycle(4'b0101, 1'b0);
        run_cycle(4'b0101, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        assert (cmd_valid_o === 1'b0) else begin errors++; $error("FAIL t5_cmd_valid observed %b expected 0", cmd_valid_o); end
        checks++;
        assert (ready_o === 4'b0000) else begin errors++; $error("FAIL t5_ready observed %b expected 0000", ready_o); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two banks always valid: capped bursts with one bubble each switch
        for (int i = 0; i < 19; i++) begin
            run_cycle(4'b0101, 1'b1);
            if (i < 8 || i == 18)        exp2 = 4'b0001;
            else if (i == 8 || i == 17)  exp2 = 4'b0000;
            else                         exp2 = 4'b0100;
            check_ready("t2_pattern", exp2);
        end
`ifdef BANK_ARB_PERF_EN
        checks++;
        assert (perf_cap_cnt_o === 16'd2) else begin errors++; $error("FAIL t2_cap observed %0d expected 2", perf_cap_cnt_o); end
`endif

        // Random traffic with sticky valids so bursts run long
        rv = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rv = N'($urandom());
            run_cycle(rv, $urandom_range(0, 3) != 0);
        end
`ifdef BANK_ARB_PERF_EN
        for (int b = 0; b < N; b++) begin
            checks++;
            assert (perf_grant_cnt_o[b*16 +: 16] === 16'(m_grants[b])) else begin
                errors++;
                $error("FAIL perf_grant bank %0d observed %0d expected %0d", b, perf_grant_cnt_o[b*16 +: 16], m_grants[b]);
            end
        end
        checks++;
        assert (perf_cap_cnt_o === 16'(m_cap)) else begin errors++; $error("FAIL perf_cap observed %0d expected %0d", perf_cap_cnt_o, m_cap); end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
